// File: rtl/bp_dcache_lce_mem_sequencer.sv
// rtl/bp_dcache_lce_mem_sequencer.sv - clears tag/stat memories after reset, then serialises LCE requests into tag/stat packets
module bp_dcache_lce_mem_sequencer #(
    parameter int sets_p      = 64,
    parameter int ways_p      = 8,
    parameter int tag_width_p = 10,
    localparam int lg_sets_lp = $clog2(sets_p),
    localparam int lg_ways_lp = $clog2(ways_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    output logic                   init_done_o,

    input  logic                   req0_v_i,
    output logic                   req0_ready_o,
    input  logic [lg_sets_lp-1:0]  req0_index_i,
    input  logic [lg_ways_lp-1:0]  req0_way_i,
    input  logic                   req0_tag_en_i,
    input  logic [1:0]             req0_tag_op_i,
    input  logic [tag_width_p-1:0] req0_tag_i,
    input  logic                   req0_stat_en_i,
    input  logic [1:0]             req0_stat_op_i,

    input  logic                   req1_v_i,
    output logic                   req1_ready_o,
    input  logic [lg_sets_lp-1:0]  req1_index_i,
    input  logic [lg_ways_lp-1:0]  req1_way_i,
    input  logic                   req1_tag_en_i,
    input  logic [1:0]             req1_tag_op_i,
    input  logic [tag_width_p-1:0] req1_tag_i,
    input  logic                   req1_stat_en_i,
    input  logic [1:0]             req1_stat_op_i,

    output logic                   tag_mem_pkt_v_o,
    output logic [lg_sets_lp-1:0]  tag_mem_pkt_index_o,
    output logic [lg_ways_lp-1:0]  tag_mem_pkt_way_o,
    output logic [1:0]             tag_mem_pkt_op_o,
    output logic [tag_width_p-1:0] tag_mem_pkt_tag_o,
    input  logic                   tag_mem_pkt_yumi_i,

    output logic                   stat_mem_pkt_v_o,
    output logic [lg_sets_lp-1:0]  stat_mem_pkt_index_o,
    output logic [lg_ways_lp-1:0]  stat_mem_pkt_way_o,
    output logic [1:0]             stat_mem_pkt_op_o,
    input  logic                   stat_mem_pkt_yumi_i
);

    typedef enum logic [1:0] {
        e_clear = 2'd0,
        e_ready = 2'd1,
        e_issue = 2'd2
    } state_e;

    state_e                  state_r, state_n;
    logic [lg_sets_lp-1:0]   sweep_cnt_r;
    logic                    tag_done_r, stat_done_r;
    logic                    init_done_r;

    logic [lg_sets_lp-1:0]   req_index_r;
    logic [lg_ways_lp-1:0]   req_way_r;
    logic                    req_tag_en_r;
    logic [1:0]              req_tag_op_r;
    logic [tag_width_p-1:0]  req_tag_r;
    logic                    req_stat_en_r;
    logic [1:0]              req_stat_op_r;

    logic tag_req, stat_req;
    logic tag_fire, stat_fire;
    logic item_done;
    logic sweep_last;
    logic hs0, hs1;

    // The clear sweep always needs both packets; a request needs only what it enabled.
    assign tag_req    = (state_r == e_clear) || req_tag_en_r;
    assign stat_req   = (state_r == e_clear) || req_stat_en_r;
    assign tag_fire   = tag_mem_pkt_v_o && tag_mem_pkt_yumi_i;
    assign stat_fire  = stat_mem_pkt_v_o && stat_mem_pkt_yumi_i;
    assign item_done  = (!tag_req || tag_done_r || tag_fire)
                     && (!stat_req || stat_done_r || stat_fire);
    assign sweep_last = (sweep_cnt_r == lg_sets_lp'(sets_p - 1));
    assign hs0        = req0_v_i && req0_ready_o;
    assign hs1        = req1_v_i && req1_ready_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= e_clear;
            sweep_cnt_r   <= '0;
            tag_done_r    <= 1'b0;
            stat_done_r   <= 1'b0;
            init_done_r   <= 1'b0;
            req_index_r   <= '0;
            req_way_r     <= '0;
            req_tag_en_r  <= 1'b0;
            req_tag_op_r  <= 2'd0;
            req_tag_r     <= '0;
            req_stat_en_r <= 1'b0;
            req_stat_op_r <= 2'd0;
        end else begin
            state_r <= state_n;

            if (state_r != e_ready && item_done) begin
                tag_done_r  <= 1'b0;
                stat_done_r <= 1'b0;
            end else begin
                tag_done_r  <= tag_done_r || tag_fire;
                stat_done_r <= stat_done_r || stat_fire;
            end

            if (state_r == e_clear && item_done) begin
                sweep_cnt_r <= sweep_cnt_r + 1'b1;
                if (sweep_last) begin
                    init_done_r <= 1'b1;
                end
            end

            if (hs0) begin
                req_index_r   <= req0_index_i;
                req_way_r     <= req0_way_i;
                req_tag_en_r  <= req0_tag_en_i;
                req_tag_op_r  <= req0_tag_op_i;
                req_tag_r     <= req0_tag_i;
                req_stat_en_r <= req0_stat_en_i;
                req_stat_op_r <= req0_stat_op_i;
            end else if (hs1) begin
                req_index_r   <= req1_index_i;
                req_way_r     <= req1_way_i;
                req_tag_en_r  <= req1_tag_en_i;
                req_tag_op_r  <= req1_tag_op_i;
                req_tag_r     <= req1_tag_i;
                req_stat_en_r <= req1_stat_en_i;
                req_stat_op_r <= req1_stat_op_i;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_clear: if (item_done && sweep_last) state_n = e_ready;
            e_ready: if (hs0 || hs1)              state_n = e_issue;
            e_issue: if (item_done)               state_n = e_ready;
            default:                              state_n = e_clear;
        endcase
    end

    always_comb begin
        init_done_o  = init_done_r;
        req0_ready_o = reset_n_i && (state_r == e_ready);
        req1_ready_o = reset_n_i && (state_r == e_ready) && !req0_v_i;

        tag_mem_pkt_v_o      = (state_r != e_ready) && tag_req && !tag_done_r;
        stat_mem_pkt_v_o     = (state_r != e_ready) && stat_req && !stat_done_r;
        tag_mem_pkt_index_o  = req_index_r;
        tag_mem_pkt_way_o    = req_way_r;
        tag_mem_pkt_op_o     = req_tag_op_r;
        tag_mem_pkt_tag_o    = req_tag_r;
        stat_mem_pkt_index_o = req_index_r;
        stat_mem_pkt_way_o   = req_way_r;
        stat_mem_pkt_op_o    = req_stat_op_r;

        if (state_r == e_clear) begin
            tag_mem_pkt_index_o  = sweep_cnt_r;
            tag_mem_pkt_way_o    = '0;
            tag_mem_pkt_op_o     = 2'd0;
            tag_mem_pkt_tag_o    = '0;
            stat_mem_pkt_index_o = sweep_cnt_r;
            stat_mem_pkt_way_o   = '0;
            stat_mem_pkt_op_o    = 2'd0;
        end
    end

endmodule

// File: tb/tb_bp_dcache_lce_mem_sequencer.sv
// tb/tb_bp_dcache_lce_mem_sequencer.sv - scoreboard bench for the dcache LCE memory sequencer
module tb_bp_dcache_lce_mem_sequencer;
    localparam int SETS = 64;
    localparam int LS   = 6;
    localparam int LW   = 3;
    localparam int TW   = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic init_done;
    logic req0_v, req0_ready, req0_tag_en, req0_stat_en;
    logic [LS-1:0] req0_index;
    logic [LW-1:0] req0_way;
    logic [1:0] req0_tag_op, req0_stat_op;
    logic [TW-1:0] req0_tag;
    logic req1_v, req1_ready, req1_tag_en, req1_stat_en;
    logic [LS-1:0] req1_index;
    logic [LW-1:0] req1_way;
    logic [1:0] req1_tag_op, req1_stat_op;
    logic [TW-1:0] req1_tag;
    logic tag_v, tag_yumi, stat_v, stat_yumi;
    logic [LS-1:0] tag_index, stat_index;
    logic [LW-1:0] tag_way, stat_way;
    logic [1:0] tag_op, stat_op;
    logic [TW-1:0] tag_tag;

    bp_dcache_lce_mem_sequencer #(.sets_p(SETS), .ways_p(8), .tag_width_p(TW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .init_done_o(init_done),
        .req0_v_i(req0_v), .req0_ready_o(req0_ready), .req0_index_i(req0_index),
        .req0_way_i(req0_way), .req0_tag_en_i(req0_tag_en), .req0_tag_op_i(req0_tag_op),
        .req0_tag_i(req0_tag), .req0_stat_en_i(req0_stat_en), .req0_stat_op_i(req0_stat_op),
        .req1_v_i(req1_v), .req1_ready_o(req1_ready), .req1_index_i(req1_index),
        .req1_way_i(req1_way), .req1_tag_en_i(req1_tag_en), .req1_tag_op_i(req1_tag_op),
        .req1_tag_i(req1_tag), .req1_stat_en_i(req1_stat_en), .req1_stat_op_i(req1_stat_op),
        .tag_mem_pkt_v_o(tag_v), .tag_mem_pkt_index_o(tag_index), .tag_mem_pkt_way_o(tag_way),
        .tag_mem_pkt_op_o(tag_op), .tag_mem_pkt_tag_o(tag_tag), .tag_mem_pkt_yumi_i(tag_yumi),
        .stat_mem_pkt_v_o(stat_v), .stat_mem_pkt_index_o(stat_index), .stat_mem_pkt_way_o(stat_way),
        .stat_mem_pkt_op_o(stat_op), .stat_mem_pkt_yumi_i(stat_yumi)
    );

    int errors = 0;
    int checks = 0;
    int ymode = 1;  // 0 random yumi, 1 always yumi, 2 driven by main sequence

    logic [LS+LW+2+TW-1:0] tq[$];
    logic [LS+LW+1:0]      sq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic fill_sweep();
        tq.delete();
        sq.delete();
        for (int i = 0; i < SETS; i++) begin
            tq.push_back({LS'(i), LW'(0), 2'd0, TW'(0)});
            sq.push_back({LS'(i), LW'(0), 2'd0});
        end
    endtask

    task automatic push_exp(input int idx, input int way, input bit ten, input int top,
                            input int tag, input bit sen, input int sop);
        if (ten) tq.push_back({LS'(idx), LW'(way), 2'(top), TW'(tag)});
        if (sen) sq.push_back({LS'(idx), LW'(way), 2'(sop)});
    endtask

    // Yumi generator: changes only at negedge, consumed by the DUT at the next posedge.
    initial forever begin
        @(negedge clk);
        if (ymode == 0) begin
            tag_yumi  = ($urandom_range(0, 9) < 6);
            stat_yumi = ($urandom_range(0, 9) < 6);
        end else if (ymode == 1) begin
            tag_yumi  = 1'b1;
            stat_yumi = 1'b1;
        end
    end

    // Monitor: pops expected packets on every accepted handshake and checks stall stability.
    initial begin : monitor
        logic pt_v, pt_y, ps_v, ps_y;
        logic [LS+LW+2+TW-1:0] pt_pkt, tpkt;
        logic [LS+LW+1:0] ps_pkt, spkt;
        pt_v = 0; pt_y = 0; ps_v = 0; ps_y = 0; pt_pkt = '0; ps_pkt = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                pt_v = 0;
                ps_v = 0;
            end else begin
                tpkt = {tag_index, tag_way, tag_op, tag_tag};
                spkt = {stat_index, stat_way, stat_op};
                if (pt_v && !pt_y) chk("tag_hold", {tag_v, tpkt}, {1'b1, pt_pkt});
                if (ps_v && !ps_y) chk("stat_hold", {stat_v, spkt}, {1'b1, ps_pkt});
                if (tag_v && tq.size() == 0) fail_now("tag_spurious");
                else if (tag_v && tag_yumi) chk("tag_pkt", tpkt, tq.pop_front());
                if (stat_v && sq.size() == 0) fail_now("stat_spurious");
                else if (stat_v && stat_yumi) chk("stat_pkt", spkt, sq.pop_front());
                pt_v = tag_v; pt_y = tag_yumi; pt_pkt = tpkt;
                ps_v = stat_v; ps_y = stat_yumi; ps_pkt = spkt;
            end
        end
    end

    task automatic do_req(input int n, input int idx, input int way, input bit ten, input int top,
                          input int tag, input bit sen, input int sop);
        bit got;
        got = 0;
        @(negedge clk);
        #1;
        if (n == 0) begin
            req0_index = LS'(idx); req0_way = LW'(way); req0_tag_en = ten; req0_tag_op = 2'(top);
            req0_tag = TW'(tag); req0_stat_en = sen; req0_stat_op = 2'(sop); req0_v = 1;
        end else begin
            req1_index = LS'(idx); req1_way = LW'(way); req1_tag_en = ten; req1_tag_op = 2'(top);
            req1_tag = TW'(tag); req1_stat_en = sen; req1_stat_op = 2'(sop); req1_v = 1;
        end
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                push_exp(idx, way, ten, top, tag, sen, sop);
                @(posedge clk);
                #1;
                req0_v = 0;
                req1_v = 0;
                got = 1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!got) begin
            req0_v = 0;
            req1_v = 0;
            fail_now("req_ready_timeout");
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((tq.size() != 0 || sq.size() != 0) && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (c >= 500) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        bit seen;
        req0_v = 0; req0_index = 0; req0_way = 0; req0_tag_en = 0; req0_tag_op = 0;
        req0_tag = 0; req0_stat_en = 0; req0_stat_op = 0;
        req1_v = 0; req1_index = 0; req1_way = 0; req1_tag_en = 0; req1_tag_op = 0;
        req1_tag = 0; req1_stat_en = 0; req1_stat_op = 0;
        tag_yumi = 0; stat_yumi = 0;
        ymode = 1;

        // Reset: no ready even with requests pending, no init_done.
        req0_v = 1; req1_v = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        chk("reset_init_done", init_done, 0);
        req0_v = 0; req1_v = 0;

        // Full sweep with yumis held high: init_done on cycle 65.
        fill_sweep();
        @(negedge clk);
        #1 reset_n = 1;
        #1;
        chk("sweep_first_index", {tag_v, stat_v, tag_index}, {1'b1, 1'b1, LS'(0)});
        k = 1;
        seen = 0;
        while (!seen && k < 80) begin
            @(negedge clk);
            #2;
            if (init_done) seen = 1;
            else k++;
        end
        chk("init_done_cycle", k + 1, 65);
        chk("sweep_queues_empty", tq.size() + sq.size(), 0);
        repeat (3) @(negedge clk);
        #2;
        chk("init_done_sticky", init_done, 1);

        // Reset in the middle of a sweep at index 20.
        reset_n = 0;
        fill_sweep();
        @(negedge clk);
        #1 reset_n = 1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            #2;
            if (tag_index == LS'(20)) seen = 1;
        end
        if (!seen) fail_now("sweep_index20_timeout");
        reset_n = 0;
        fill_sweep();
        @(negedge clk);
        #1 reset_n = 1;
        #1;
        chk("reset_mid_index", {tag_v, tag_index, stat_index}, {1'b1, LS'(0), LS'(0)});
        chk("reset_mid_init_done", init_done, 0);

        // Skewed yumi on index 5: tag at cycle 1, stat at cycle 3.
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            #2;
            if (tag_index == LS'(5)) seen = 1;
        end
        if (!seen) fail_now("sweep_index5_timeout");
        ymode = 2;
        tag_yumi = 1;
        stat_yumi = 0;
        @(negedge clk);
        #2;
        tag_yumi = 0;
        chk("skew_c2", {tag_v, stat_v, stat_index, stat_op}, {1'b0, 1'b1, LS'(5), 2'd0});
        @(negedge clk);
        #2;
        chk("skew_c3", {tag_v, stat_v, stat_index}, {1'b0, 1'b1, LS'(5)});
        stat_yumi = 1;
        @(negedge clk);
        #2;
        chk("skew_advance", {tag_v, stat_v, tag_index}, {1'b1, 1'b1, LS'(6)});
        ymode = 1;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (init_done) seen = 1;
        end
        chk("skew_init_done", seen, 1);
        wait_drain();

        // Priority: req0 wins, req1 served later with its own fields.
        ymode = 0;
        @(negedge clk);
        #1;
        req0_index = 6'd12; req0_way = 3'd1; req0_tag_en = 1; req0_tag_op = 2'd2; req0_tag = 10'h155;
        req0_stat_en = 1; req0_stat_op = 2'd1; req0_v = 1;
        req1_index = 6'd33; req1_way = 3'd6; req1_tag_en = 1; req1_tag_op = 2'd1; req1_tag = 10'h0F0;
        req1_stat_en = 1; req1_stat_op = 2'd2; req1_v = 1;
        #1;
        chk("prio_ready0", req0_ready, 1);
        chk("prio_ready1", req1_ready, 0);
        push_exp(12, 1, 1, 2, 'h155, 1, 1);
        @(posedge clk);
        #1 req0_v = 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #2;
            if (req1_ready) begin
                push_exp(33, 6, 1, 1, 'h0F0, 1, 2);
                @(posedge clk);
                #1 req1_v = 0;
                seen = 1;
            end
        end
        chk("prio_req1_served", seen, 1);
        req1_v = 0;
        wait_drain();

        // Stat-only request on req1.
        do_req(1, 7, 3, 0, 0, 0, 1, 3);
        wait_drain();

        // Backpressure on a set_tag packet.
        ymode = 2;
        tag_yumi = 0;
        stat_yumi = 0;
        do_req(0, 9, 5, 1, 2, 'h2A5, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            chk("bp_hold", {tag_v, stat_v, tag_index, tag_way, tag_op, tag_tag},
                {1'b1, 1'b0, LS'(9), LW'(5), 2'd2, TW'('h2A5)});
        end
        tag_yumi = 1;
        @(negedge clk);
        #2;
        tag_yumi = 0;
        chk("bp_done", {tag_v, req0_ready}, {1'b0, 1'b1});
        ymode = 0;

        // Request with no packets completes in one issue cycle.
        do_req(0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("empty_req_ready", {tag_v, stat_v, req0_ready}, {1'b0, 1'b0, 1'b1});

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            do_req($urandom_range(0, 1), $urandom_range(0, SETS - 1), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 1023),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        wait_drain();
        chk("final_queues_empty", tq.size() + sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_dcache_lce_mem_sequencer.md
BP_DCACHE_LCE_MEM_SEQUENCER -- requirements
Module: bp_dcache_lce_mem_sequencer

Interface
REQ-001 SHALL have parameter sets_p, default 64, meaning the number of cache sets (power of two, at least 2); lg_sets_lp = log2(sets_p).
REQ-002 SHALL have parameter ways_p, default 8, meaning associativity; lg_ways_lp = log2(ways_p).
REQ-003 SHALL have parameter tag_width_p, default 10, meaning tag width.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 Ports (name, direction, width, meaning):
 - clk_i  in  1  clock.
 - reset_n_i  in  1  synchronous active-low reset.
 - init_done_o  out  1  clear sweep finished.
 - reqN_v_i  in  1  request valid, N = 0 or 1.
 - reqN_ready_o  out  1  request accepted this cycle when reqN_v_i is also high.
 - reqN_index_i  in  lg_sets_lp  set index.
 - reqN_way_i  in  lg_ways_lp  way.
 - reqN_tag_en_i  in  1  request needs a tag_mem packet.
 - reqN_tag_op_i  in  2  tag_mem opcode: 0 set_clear, 1 invalidate, 2 set_tag.
 - reqN_tag_i  in  tag_width_p  tag for set_tag.
 - reqN_stat_en_i  in  1  request needs a stat_mem packet.
 - reqN_stat_op_i  in  2  stat_mem opcode: 0 set_clear, 1 read, 2 clear_dirty, 3 set_lru.
 - tag_mem_pkt_v_o  out  1  tag packet valid.
 - tag_mem_pkt_index_o  out  lg_sets_lp  tag packet index.
 - tag_mem_pkt_way_o  out  lg_ways_lp  tag packet way.
 - tag_mem_pkt_op_o  out  2  tag packet opcode.
 - tag_mem_pkt_tag_o  out  tag_width_p  tag packet tag.
 - tag_mem_pkt_yumi_i  in  1  tag packet consumed.
 - stat_mem_pkt_v_o  out  1  stat packet valid.
 - stat_mem_pkt_index_o  out  lg_sets_lp  stat packet index.
 - stat_mem_pkt_way_o  out  lg_ways_lp  stat packet way.
 - stat_mem_pkt_op_o  out  2  stat packet opcode.
 - stat_mem_pkt_yumi_i  in  1  stat packet consumed.

Function
REQ-006 SHALL implement the states e_clear, e_ready and e_issue.
REQ-007 In e_clear, SHALL drive both packet valids high with index equal to the sweep counter, way 0, and opcode set_clear on both memories.
REQ-008 SHALL keep one sticky accepted flag per memory; a valid is dropped once its yumi is seen for the current item.
REQ-009 SHALL advance the sweep counter only when both packets of the current index are accepted, in the same cycle or in different cycles, then clear both flags.
REQ-010 On acceptance at index sets_p-1, SHALL go to e_ready and set init_done_o the next cycle; init_done_o then stays high until reset.
REQ-011 reqN_ready_o SHALL be high only in e_ready; arbitration is fixed priority, req0 over req1, and ready is given to one requester at most.
REQ-012 On handshake, SHALL latch all request fields and go to e_issue; packet valids rise the cycle after acceptance (1-cycle latency).
REQ-013 In e_issue, SHALL drive tag_mem_pkt_v_o only if tag_en was latched and stat_mem_pkt_v_o only if stat_en was latched, from the latched fields.
REQ-014 SHALL return to e_ready when every required packet has been accepted.
REQ-015 SHALL hold packet fields stable while the corresponding valid is high and yumi is low.
REQ-016 A request with tag_en=0 and stat_en=0 SHALL be accepted and completed in e_issue in one cycle with no packet issued.
REQ-017 Packet valids SHALL be 0 in e_ready.
REQ-018 Yumi with valid low SHALL be ignored.
REQ-019 Minimum request spacing SHALL be 2 cycles.

Reset
REQ-020 While reset_n_i=0 at a clock edge, SHALL set state=e_clear, sweep counter=0, flags=0 and init_done_o=0.
REQ-021 During reset, SHALL hold both ready outputs at 0.
REQ-022 Reset mid-sweep or mid-issue SHALL abandon the operation and restart the sweep at index 0; no partial request survives.

Verification
REQ-023 Sweep: sets_p=64, both yumis held at 1 -> 64 cycles of set_clear with indices 0..63, init_done_o=1 on cycle 65, no index skipped or repeated.
REQ-024 Skewed yumi: tag yumi at cycle 1 and stat yumi at cycle 3 for index 5 -> tag valid low in cycles 2-3, stat op held, counter moves to 6 only after cycle 3.
REQ-025 Priority: req0 and req1 both valid in e_ready -> req0_ready_o=1 and req1_ready_o=0; req1 is served in the next e_ready cycle with its fields unchanged.
REQ-026 Partial request: req1 with tag_en=0, stat_en=1, op set_lru, index 7, way 3 -> only stat packet (7, 3, 3) issued and tag valid never rises.
REQ-027 Reset at sweep index 20 -> next cycle after reset release shows index 0, init_done_o=0.
REQ-028 Backpressure: set_tag, tag 0x2A5, yumi low for 4 cycles -> fields constant for 4 cycles, single acceptance, return to e_ready.
